// File: rtl/lcd_spi_stream_writer_pkg.sv
// Shared definitions for the LCD SPI stream writer: FSM states, FIFO entry layout, DC constants.
// Entries are packed as {dc, w16, data}, DATA_W+2 bits wide.
package lcd_spi_stream_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP
  } state_t;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  localparam int ENTRY_EXTRA_BITS = 2;

  function automatic int entry_w16_bit(int data_w);
    return data_w;
  endfunction

  function automatic int entry_dc_bit(int data_w);
    return data_w + 1;
  endfunction

  function automatic logic [4:0] word_bits(logic w16, int data_w);
    return w16 ? 5'(data_w) : 5'd8;
  endfunction

endpackage

// File: rtl/lcd_spi_stream_writer_if.sv
// Write-side handshake and LCD pin bundle for the LCD SPI stream writer.
// The writer itself attaches through the slave modport.
interface lcd_spi_stream_writer_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               wr_en;
  logic               wr_dc;
  logic               wr_w16;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_ready;
  logic [LEVEL_W-1:0] fifo_level;
  logic               ovf;
  logic               busy;
  logic               word_done;
  logic               cs;
  logic               dc;
  logic               sclk;
  logic               mosi;

  modport master (
    output wr_en, wr_dc, wr_w16, wr_data,
    input  wr_ready, fifo_level, ovf, busy, word_done, cs, dc, sclk, mosi
  );

  modport slave (
    input  wr_en, wr_dc, wr_w16, wr_data,
    output wr_ready, fifo_level, ovf, busy, word_done, cs, dc, sclk, mosi
  );

endinterface

// File: rtl/lcd_spi_stream_writer_fifo.sv
// Generic single-clock show-ahead FIFO with level/full/empty; a push while full is ignored.
// rd_data always presents the head entry so the consumer can peek before popping.
module lcd_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push;
  logic             w_pop;

  assign full    = (r_level == (PTR_W+1)'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (PTR_W+1)'(1);
        2'b01:   r_level <= r_level - (PTR_W+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_spi_stream_writer.sv
// Buffered SPI mode-0 writer for an ST7735: queues {dc, w16, data} entries and shifts them MSB first.
// CS stays low across queued words so pixel bursts stream back to back.
module lcd_spi_stream_writer
  import lcd_spi_stream_writer_pkg::*;
#(
  parameter int HALFDIV    = 2,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CS_GAP     = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  lcd_spi_stream_writer_if.slave bus
);

  localparam int ENTRY_W = DATA_W + ENTRY_EXTRA_BITS;
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int HCNT_W  = $clog2(HALFDIV + 1);
  localparam int GCNT_W  = $clog2(CS_GAP + 1);
  localparam int DC_BIT  = entry_dc_bit(DATA_W);
  localparam int W16_BIT = entry_w16_bit(DATA_W);

  state_t              r_state;
  logic                r_cs;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_dc;
  logic                r_word_done;
  logic                r_ovf;
  logic [DATA_W-1:0]   r_shreg;
  logic [4:0]          r_bitcnt;
  logic [HCNT_W-1:0]   r_hcnt;
  logic [GCNT_W-1:0]   r_gapcnt;

  logic [ENTRY_W-1:0]  w_head;
  logic [LEVEL_W-1:0]  w_level;
  logic                w_full;
  logic                w_empty;
  logic                w_head_dc;
  logic                w_head_w16;
  logic [DATA_W-1:0]   w_head_data;
  logic [DATA_W-1:0]   w_head_aligned;
  logic                w_head_msb;

  lcd_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .wr_en   (bus.wr_en),
    .wr_data ({bus.wr_dc, bus.wr_w16, bus.wr_data}),
    .rd_en   (r_state == ST_LOAD),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  // 8-bit entries are left-aligned so the shifter always emits from its top bit.
  assign w_head_dc      = w_head[DC_BIT];
  assign w_head_w16     = w_head[W16_BIT];
  assign w_head_data    = w_head[DATA_W-1:0];
  assign w_head_aligned = w_head_w16 ? w_head_data : (w_head_data << (DATA_W - 8));
  assign w_head_msb     = w_head_w16 ? w_head_data[DATA_W-1] : w_head_data[7];

  assign bus.wr_ready   = !w_full;
  assign bus.fifo_level = w_level;
  assign bus.ovf        = r_ovf;
  assign bus.busy       = !w_empty || (r_state != ST_IDLE);
  assign bus.word_done  = r_word_done;
  assign bus.cs         = r_cs;
  assign bus.dc         = r_dc;
  assign bus.sclk       = r_sclk;
  assign bus.mosi       = r_mosi;

  // cs/dc/mosi are set on the edge entering LOAD, so they are already valid during the pop cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_cs        <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_dc        <= DC_CMD;
      r_word_done <= 1'b0;
      r_ovf       <= 1'b0;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_hcnt      <= '0;
      r_gapcnt    <= '0;
    end else begin
      r_word_done <= 1'b0;
      r_ovf       <= bus.wr_en && w_full;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_LOAD;
            r_cs    <= 1'b0;
            r_dc    <= w_head_dc;
            r_mosi  <= w_head_msb;
          end
        end
        ST_LOAD: begin
          r_shreg  <= w_head_aligned;
          r_bitcnt <= word_bits(w_head_w16, DATA_W);
          r_hcnt   <= '0;
          r_sclk   <= 1'b0;
          r_state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (r_hcnt == HCNT_W'(HALFDIV - 1)) begin
            r_hcnt <= '0;
            if (!r_sclk) begin
              r_sclk <= 1'b1;
            end else begin
              r_sclk <= 1'b0;
              if (r_bitcnt == 5'd1) begin
                r_word_done <= 1'b1;
                if (!w_empty) begin
                  r_state <= ST_LOAD;
                  r_dc    <= w_head_dc;
                  r_mosi  <= w_head_msb;
                end else begin
                  r_state  <= ST_GAP;
                  r_cs     <= 1'b1;
                  r_mosi   <= 1'b0;
                  r_gapcnt <= '0;
                end
              end else begin
                r_bitcnt <= r_bitcnt - 5'd1;
                r_shreg  <= r_shreg << 1;
                r_mosi   <= r_shreg[DATA_W-2];
              end
            end
          end else begin
            r_hcnt <= r_hcnt + HCNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_gapcnt == GCNT_W'(CS_GAP - 1)) r_state <= ST_IDLE;
          else                                 r_gapcnt <= r_gapcnt + GCNT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_stream_writer.sv
// Self-checking bench for lcd_spi_stream_writer: pushes directed and random entries, decodes the
// SPI pins on every sclk rise and compares each finished word against a queue of pushed entries.
module tb_lcd_spi_stream_writer;
  import lcd_spi_stream_writer_pkg::*;

  localparam int HALFDIV    = 2;
  localparam int DATA_W     = 16;
  localparam int FIFO_DEPTH = 16;
  localparam int CS_GAP     = 2;

  typedef struct {
    logic        dc;
    logic        w16;
    logic [15:0] data;
  } entry_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  lcd_spi_stream_writer_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  lcd_spi_stream_writer #(
    .HALFDIV    (HALFDIV),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CS_GAP     (CS_GAP)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int cycle = 0;
  always @(posedge sys_clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  entry_t expQ[$];
  int     wdTimes[$];
  int     csFallTimes[$];
  int     segList[$];

  int          curBits = 0;
  logic [15:0] curVal = '0;
  logic        curDc = 1'b0;
  int          segRises = 0;
  int          csRiseCycle = 0;
  int          mosiHighChanges = 0;
  int          dcChanges = 0;
  int          csMidWord = 0;
  int          riseWhileCsHigh = 0;
  int          ovfPulses = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference model of one word: what a mode-0 sampler must reconstruct from an entry.
  task automatic scoreWord();
    entry_t      e;
    logic [15:0] gotVal;
    if (expQ.size() == 0) begin
      checkOutput("unexpectedWord", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      gotVal = (curBits == 8) ? (curVal & 16'h00FF) : curVal;
      checkOutput("wordBits", curBits, e.w16 ? 16 : 8);
      checkOutput("wordDc", curDc, e.dc);
      checkOutput("wordData", gotVal, e.w16 ? e.data : {8'h00, e.data[7:0]});
    end
  endtask

  // Pin-level monitor: samples on the falling sys_clk edge, decodes bits on sclk rises.
  initial begin
    logic prevSclk;
    logic prevMosi;
    logic prevCs;
    prevSclk = 1'b0;
    prevMosi = 1'b0;
    prevCs   = 1'b1;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        curBits  = 0;
        segRises = 0;
        prevSclk = 1'b0;
        prevMosi = 1'b0;
        prevCs   = 1'b1;
      end else begin
        if (prevSclk && bus.sclk && (bus.mosi !== prevMosi)) mosiHighChanges++;
        if (!prevSclk && bus.sclk) begin
          if (bus.cs) riseWhileCsHigh++;
          if (curBits == 0) curDc = bus.dc;
          else if (bus.dc !== curDc) dcChanges++;
          curVal = {curVal[14:0], bus.mosi};
          curBits++;
          segRises++;
        end
        if (bus.word_done) begin
          wdTimes.push_back(cycle);
          scoreWord();
          curBits = 0;
        end
        if (prevCs && !bus.cs) begin
          csFallTimes.push_back(cycle);
          checkOutput("csGap", ((cycle - csRiseCycle) >= CS_GAP), 1);
          segRises = 0;
        end
        if (!prevCs && bus.cs) begin
          if (curBits != 0) csMidWord++;
          csRiseCycle = cycle;
          segList.push_back(segRises);
        end
        if (bus.ovf) ovfPulses++;
        prevSclk = bus.sclk;
        prevMosi = bus.mosi;
        prevCs   = bus.cs;
      end
    end
  end

  // Drives one push for a single cycle; entries expected to be accepted go to the scoreboard.
  task automatic applyStimulus(input logic dc, input logic w16, input logic [15:0] data, input bit expectAccept);
    entry_t e;
    bus.wr_en   = 1'b1;
    bus.wr_dc   = dc;
    bus.wr_w16  = w16;
    bus.wr_data = data;
    if (expectAccept) begin
      e.dc = dc; e.w16 = w16; e.data = data;
      expQ.push_back(e);
    end
    @(posedge sys_clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (bus.busy !== 1'b0 && n < maxCycles) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("drainedInTime", bus.busy, 1'b0);
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wIdx;
    int fIdx;
    int sIdx;
    int ovfStart;
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_dc   = 1'b0;
    bus.wr_w16  = 1'b0;
    bus.wr_data = '0;

    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("rstCs", bus.cs, 1'b1);
    checkOutput("rstSclk", bus.sclk, 1'b0);
    checkOutput("rstMosi", bus.mosi, 1'b0);
    checkOutput("rstDc", bus.dc, 1'b0);
    checkOutput("rstOvf", bus.ovf, 1'b0);
    checkOutput("rstWordDone", bus.word_done, 1'b0);
    checkOutput("rstBusy", bus.busy, 1'b0);
    checkOutput("rstWrReady", bus.wr_ready, 1'b1);
    checkOutput("rstLevel", bus.fifo_level, 0);
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Single command 0x2A: 8 rises, 33-cycle latency from LOAD to word_done.
    wIdx = wdTimes.size(); fIdx = csFallTimes.size(); sIdx = segList.size();
    applyStimulus(DC_CMD, 1'b0, 16'h002A, 1'b1);
    waitIdle(200);
    checkOutput("cmdWordCount", wdTimes.size() - wIdx, 1);
    checkOutput("cmdLatency", (wdTimes.size() > wIdx && csFallTimes.size() > fIdx) ?
                wdTimes[wIdx] - csFallTimes[fIdx] : -1, 1 + 2 * 8 * HALFDIV);
    checkOutput("cmdRises", (segList.size() > sIdx) ? segList[sIdx] : -1, 8);
    checkOutput("csHighAfterCmd", bus.cs, 1'b1);

    // Four RGB565 red pixels back to back: one CS-low burst of 64 rises.
    wIdx = wdTimes.size(); fIdx = csFallTimes.size(); sIdx = segList.size();
    for (int i = 0; i < 4; i++) applyStimulus(DC_DATA, 1'b1, 16'hF800, 1'b1);
    waitIdle(600);
    checkOutput("pixWordCount", wdTimes.size() - wIdx, 4);
    checkOutput("pixBursts", segList.size() - sIdx, 1);
    checkOutput("pixRises", (segList.size() > sIdx) ? segList[sIdx] : -1, 64);
    checkOutput("pixLatency", (wdTimes.size() > wIdx && csFallTimes.size() > fIdx) ?
                wdTimes[wIdx] - csFallTimes[fIdx] : -1, 1 + 2 * 16 * HALFDIV);
    for (int i = 1; i < 4; i++)
      checkOutput("pixSpacing", (wdTimes.size() > wIdx + i) ?
                  wdTimes[wIdx + i] - wdTimes[wIdx + i - 1] : -1, 1 + 2 * 16 * HALFDIV);

    // Push every cycle from idle: entry 0 is popped on the third cycle (push and pop together),
    // so the FIFO reaches 16 after push 16 and push 17 is the one that overflows.
    ovfStart = ovfPulses;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      applyStimulus(DC_CMD, 1'b0, 16'(i * 7 + 3), i <= FIFO_DEPTH);
      checkOutput("fifoLevel", bus.fifo_level, (i == 0) ? 1 : (i == 1) ? 2 : (i > FIFO_DEPTH) ? FIFO_DEPTH : i);
    end
    checkOutput("fullNotReady", bus.wr_ready, 1'b0);
    @(negedge sys_clk);
    checkOutput("ovfPulseCount", ovfPulses - ovfStart, 1);
    waitIdle(FIFO_DEPTH * 40 + 100);

    // Reset while the fifth bit of a pixel is on the wire, with more entries queued behind it.
    applyStimulus(DC_DATA, 1'b1, 16'hA5C3, 1'b1);
    applyStimulus(DC_CMD, 1'b0, 16'h0055, 1'b1);
    applyStimulus(DC_DATA, 1'b1, 16'h1234, 1'b1);
    n = 0;
    while (curBits < 5 && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    checkOutput("reachedBit5", curBits >= 5, 1);
    #2 sys_rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("abortCs", bus.cs, 1'b1);
    checkOutput("abortSclk", bus.sclk, 1'b0);
    checkOutput("abortMosi", bus.mosi, 1'b0);
    checkOutput("abortLevel", bus.fifo_level, 0);
    checkOutput("abortBusy", bus.busy, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    wIdx = wdTimes.size();
    applyStimulus(DC_CMD, 1'b0, 16'h0001, 1'b1);
    waitIdle(200);
    checkOutput("postResetWords", wdTimes.size() - wIdx, 1);

    // Random batches small enough never to overflow; long gaps land pushes inside GAP.
    for (int b = 0; b < 6; b++) begin
      int cnt;
      int gapMax;
      cnt = $urandom_range(3, 12);
      gapMax = (b % 2 == 1) ? 3 : 45;
      wIdx = wdTimes.size();
      for (int k = 0; k < cnt; k++) begin
        applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 1'b1);
        repeat ($urandom_range(0, gapMax)) begin
          @(posedge sys_clk);
          #1;
        end
      end
      waitIdle(12 * 80 + 200);
      checkOutput("randWordCount", wdTimes.size() - wIdx, cnt);
    end

    checkOutput("mosiStableWhileHigh", mosiHighChanges, 0);
    checkOutput("dcStableInWord", dcChanges, 0);
    checkOutput("csHeldMidWord", csMidWord, 0);
    checkOutput("riseOnlyWithCsLow", riseWhileCsHigh, 0);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    checkOutput("ovfTotal", ovfPulses, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
